bist_signature_checker: RTL and testbench

- Response-side companion to the BIST test controller; consumes its SISA_En, MISR_En, done and rstOut strobes.
- Compacts the serial scan-out stream into a SISA signature and the parallel CUT outputs into a MISR signature.
- Counts the enable strobes, compares both signatures and both counts against golden parameters at end of test, and holds a sticky pass/fail verdict for the top level.

---
 rtl/bist_signature_checker.sv | 150 +++++++++++++++
 tb/tb_bist_signature_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_signature_checker.sv
// BIST response checker: compacts scan-out into a SISA and CUT outputs into a MISR,
// counts the enable strobes and holds a sticky pass/fail verdict after end of test.
module bist_signature_checker #(
    parameter int                MISR_W       = 16,
    parameter logic [MISR_W-1:0] MISR_POLY    = 16'h1021,
    parameter int                SISA_W       = 16,
    parameter logic [SISA_W-1:0] SISA_POLY    = 16'h1021,
    parameter logic [MISR_W-1:0] GOLD_MISR    = 16'h0000,
    parameter logic [SISA_W-1:0] GOLD_SISA    = 16'h0000,
    parameter int                EXP_MISR_CNT = 45,
    parameter int                EXP_SISA_CNT = 2025,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rstIn,
    input  logic              rstOut,
    input  logic              SISA_En,
    input  logic              MISR_En,
    input  logic              done,
    input  logic              scanOut,
    input  logic [MISR_W-1:0] cutOut,
    output logic [MISR_W-1:0] misrSig,
    output logic [SISA_W-1:0] sisaSig,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [2:0]        errFlags
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_COMPARE,
        ST_REPORT
    } state_t;

    localparam logic [CNT_W-1:0] EXP_MISR_CNT_C = CNT_W'(EXP_MISR_CNT);
    localparam logic [CNT_W-1:0] EXP_SISA_CNT_C = CNT_W'(EXP_SISA_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX        = '1;

    state_t            state_q, state_d;
    logic [MISR_W-1:0] misr_q, misr_d;
    logic [SISA_W-1:0] sisa_q, sisa_d;
    logic [CNT_W-1:0]  misr_cnt_q, misr_cnt_d;
    logic [CNT_W-1:0]  sisa_cnt_q, sisa_cnt_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [2:0]        err_q, err_d;

    logic [MISR_W-1:0] misr_next;
    logic [SISA_W-1:0] sisa_next;
    logic [2:0]        cmp_flags;

    assign misr_next = {misr_q[MISR_W-2:0], 1'b0}
                     ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                     ^ cutOut;
    assign sisa_next = {sisa_q[SISA_W-2:0], 1'b0}
                     ^ (sisa_q[SISA_W-1] ? SISA_POLY : '0)
                     ^ {{(SISA_W-1){1'b0}}, scanOut};

    assign cmp_flags = {(misr_cnt_q != EXP_MISR_CNT_C) | (sisa_cnt_q != EXP_SISA_CNT_C),
                        sisa_q != GOLD_SISA,
                        misr_q != GOLD_MISR};

    // NOTE: every variable gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        misr_d     = misr_q;
        sisa_d     = sisa_q;
        misr_cnt_d = misr_cnt_q;
        sisa_cnt_d = sisa_cnt_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_d      = err_q;

        if (rstOut) begin
            // Run start beats every strobe sampled in the same cycle.
            state_d    = ST_RUN;
            misr_d     = '0;
            sisa_d     = '0;
            misr_cnt_d = '0;
            sisa_cnt_d = '0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            err_d      = 3'b000;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (done) begin
                        state_d = ST_REPORT;
                        fail_d  = 1'b1;
                        err_d   = 3'b100;
                    end
                end
                ST_RUN: begin
                    if (MISR_En) begin
                        misr_d = misr_next;
                        if (misr_cnt_q != CNT_MAX) misr_cnt_d = misr_cnt_q + 1'b1;
                    end
                    if (SISA_En) begin
                        sisa_d = sisa_next;
                        if (sisa_cnt_q != CNT_MAX) sisa_cnt_d = sisa_cnt_q + 1'b1;
                    end
                    if (done) state_d = ST_COMPARE;
                end
                ST_COMPARE: begin
                    err_d   = cmp_flags;
                    pass_d  = (cmp_flags == 3'b000);
                    fail_d  = (cmp_flags != 3'b000);
                    state_d = ST_REPORT;
                end
                ST_REPORT: begin
                    state_d = ST_REPORT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstIn) begin
            state_q    <= ST_IDLE;
            misr_q     <= '0;
            sisa_q     <= '0;
            misr_cnt_q <= '0;
            sisa_cnt_q <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            misr_q     <= misr_d;
            sisa_q     <= sisa_d;
            misr_cnt_q <= misr_cnt_d;
            sisa_cnt_q <= sisa_cnt_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
        end
    end

    assign misrSig  = misr_q;
    assign sisaSig  = sisa_q;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_COMPARE);
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign errFlags = err_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Directed bench for bist_signature_checker: arithmetic vectors, full 45x45 runs with
// golds from a reference model, count/signature errors, protocol and priority cases.
module tb_bist_signature_checker;

    localparam int RUNS  = 45;
    localparam int SHIFT = 45;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic [15:0] inj);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ inj;
    endfunction

    function automatic logic scan_bit(input int r, input int k);
        return (((r * 5) + (k * 3)) % 7) < 3;
    endfunction

    function automatic logic [15:0] cut_word(input int r);
        return 16'hA5A5 ^ 16'(r * 263);
    endfunction

    function automatic logic [15:0] gold_misr(input int runs);
        logic [15:0] m;
        m = 16'h0000;
        for (int r = 0; r < runs; r++) m = lfsr_step(m, cut_word(r));
        return m;
    endfunction

    function automatic logic [15:0] gold_sisa(input int runs);
        logic [15:0] s;
        s = 16'h0000;
        for (int r = 0; r < runs; r++)
            for (int k = 0; k < SHIFT; k++)
                s = lfsr_step(s, {15'b0, scan_bit(r, k)});
        return s;
    endfunction

    localparam logic [15:0] G_MISR = gold_misr(RUNS);
    localparam logic [15:0] G_SISA = gold_sisa(RUNS);

    logic        clk = 1'b0;
    logic        rstIn, rstOut, SISA_En, MISR_En, done, scanOut;
    logic [15:0] cutOut;
    logic [15:0] misrSig, sisaSig;
    logic        busy, pass, fail;
    logic [2:0]  errFlags;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_model, s_model;

    bist_signature_checker #(
        .GOLD_MISR(G_MISR),
        .GOLD_SISA(G_SISA)
    ) dut (
        .clk(clk), .rstIn(rstIn), .rstOut(rstOut), .SISA_En(SISA_En), .MISR_En(MISR_En),
        .done(done), .scanOut(scanOut), .cutOut(cutOut), .misrSig(misrSig),
        .sisaSig(sisaSig), .busy(busy), .pass(pass), .fail(fail), .errFlags(errFlags)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one complete session: rstOut, RUNS x (SHIFT SISA shifts + 1 MISR capture), done.
    // Returns after the edge that ends COMPARE, i.e. verdict should be visible.
    task automatic run_session(input int drop_run, input int flip_run,
                               output logic [15:0] m, output logic [15:0] s);
        m = 16'h0000;
        s = 16'h0000;
        rstOut = 1'b1;
        tick();
        rstOut = 1'b0;
        for (int r = 0; r < RUNS; r++) begin
            for (int k = 0; k < SHIFT; k++) begin
                SISA_En = 1'b1;
                scanOut = scan_bit(r, k) ^ ((r == flip_run) && (k == 0));
                s = lfsr_step(s, {15'b0, scanOut});
                tick();
            end
            SISA_En = 1'b0;
            scanOut = 1'b0;
            if (r != drop_run) begin
                MISR_En = 1'b1;
                cutOut  = cut_word(r);
                m = lfsr_step(m, cutOut);
                tick();
                MISR_En = 1'b0;
            end
        end
        check("run_misr", misrSig, m);
        check("run_sisa", sisaSig, s);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("compare_busy", busy, 1'b1);
        check("compare_no_verdict", {pass, fail}, 2'b00);
        tick();
    endtask

    initial begin
        rstIn = 1'b0; rstOut = 1'b0; SISA_En = 1'b0; MISR_En = 1'b0;
        done = 1'b0; scanOut = 1'b0; cutOut = 16'h0000;
        tick();
        tick();
        check("reset_misr", misrSig, 16'h0000);
        check("reset_sisa", sisaSig, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_passfail", {pass, fail}, 2'b00);
        check("reset_err", errFlags, 3'b000);
        rstIn = 1'b1;

        // MISR arithmetic
        rstOut = 1'b1;
        tick();
        rstOut = 1'b0;
        check("start_busy", busy, 1'b1);
        MISR_En = 1'b1; cutOut = 16'hA5A5;
        tick();
        check("misr_a5a5", misrSig, 16'hA5A5);
        cutOut = 16'h0000;
        tick();
        check("misr_fold", misrSig, 16'h5B6B);

        // Reset mid-run overrides the enable held high
        rstIn = 1'b0; SISA_En = 1'b1; scanOut = 1'b1;
        tick();
        check("midreset_misr", misrSig, 16'h0000);
        check("midreset_sisa", sisaSig, 16'h0000);
        check("midreset_busy", busy, 1'b0);
        check("midreset_passfail", {pass, fail}, 2'b00);
        check("midreset_err", errFlags, 3'b000);
        rstIn = 1'b1; MISR_En = 1'b0; SISA_En = 1'b0; scanOut = 1'b0;

        // Enables ignored in IDLE
        MISR_En = 1'b1; cutOut = 16'h1234;
        tick();
        MISR_En = 1'b0;
        check("idle_ignore_misr", misrSig, 16'h0000);

        // SISA arithmetic
        rstOut = 1'b1;
        tick();
        rstOut = 1'b0;
        SISA_En = 1'b1; scanOut = 1'b1;
        tick();
        check("sisa_1", sisaSig, 16'h0001);
        tick();
        check("sisa_3", sisaSig, 16'h0003);
        tick();
        check("sisa_7", sisaSig, 16'h0007);
        scanOut = 1'b0;
        tick();
        check("sisa_e", sisaSig, 16'h000E);
        SISA_En = 1'b0;

        // rstOut wins over a simultaneous MISR_En
        MISR_En = 1'b1; cutOut = 16'hBEEF;
        tick();
        check("pre_prio_misr", misrSig, 16'hBEEF);
        rstOut = 1'b1; cutOut = 16'h1234;
        tick();
        rstOut = 1'b0; MISR_En = 1'b0;
        check("prio_misr", misrSig, 16'h0000);
        check("prio_sisa", sisaSig, 16'h0000);
        check("prio_busy", busy, 1'b1);

        // done in IDLE is a protocol error
        rstIn = 1'b0;
        tick();
        rstIn = 1'b1;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("idle_done_fail", {pass, fail}, 2'b01);
        check("idle_done_err", errFlags, 3'b100);
        check("idle_done_busy", busy, 1'b0);
        tick();
        check("idle_done_sticky", {pass, fail}, 2'b01);

        // Full passing run
        run_session(-1, -1, m_model, s_model);
        check("pass_gold_misr", misrSig, G_MISR);
        check("pass_gold_sisa", sisaSig, G_SISA);
        check("pass_passfail", {pass, fail}, 2'b10);
        check("pass_err", errFlags, 3'b000);
        check("pass_busy", busy, 1'b0);
        tick();
        check("pass_sticky", {pass, fail}, 2'b10);

        // rstOut in REPORT restarts a run
        rstOut = 1'b1;
        tick();
        rstOut = 1'b0;
        check("restart_passfail", {pass, fail}, 2'b00);
        check("restart_busy", busy, 1'b1);
        check("restart_err", errFlags, 3'b000);

        // One MISR_En dropped: count error
        run_session(10, -1, m_model, s_model);
        check("drop_passfail", {pass, fail}, 2'b01);
        check("drop_err_cnt", errFlags[2], 1'b1);
        MISR_En = 1'b1; SISA_En = 1'b1; scanOut = 1'b1; cutOut = 16'hFFFF; done = 1'b1;
        tick();
        tick();
        MISR_En = 1'b0; SISA_En = 1'b0; scanOut = 1'b0; done = 1'b0;
        check("report_frozen_misr", misrSig, m_model);
        check("report_frozen_sisa", sisaSig, s_model);
        check("report_frozen_verdict", {pass, fail}, 2'b01);
        check("report_busy", busy, 1'b0);

        // One flipped scan bit: SISA mismatch only
        run_session(-1, 20, m_model, s_model);
        check("flip_misr_gold", misrSig, G_MISR);
        check("flip_passfail", {pass, fail}, 2'b01);
        check("flip_err", errFlags, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
